// File: rtl/puf_resp_uart_tx.sv
// puf_resp_uart_tx: captures a PUF challenge/response pair on a done rising edge and sends both bytes over UART.
// Define PUF_TX_PARITY_EN to append an even-parity bit after bit 7 of every frame.
module puf_resp_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       done,
    input  logic [7:0] challenge,
    input  logic [7:0] response,
    output logic       computer_ack,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PUF_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_ACK    = 3'd5;
    localparam logic [15:0] RELOAD  = 16'(CLKS_PER_BIT - 1);

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic        r_second;
    logic [7:0]  r_chal;
    logic [7:0]  r_resp;
    logic        r_s1;
    logic        r_s2;
    logic        r_s3;
    logic        r_tx;
    logic        r_busy;
    logic        r_ack;
    logic        r_ovr;
    logic        w_rise;
    logic        w_bit_end;
    logic [7:0]  w_byte;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_bit_end = r_cnt == 16'd0;
    assign w_byte    = r_second ? r_resp : r_chal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 16'd0;
            r_idx    <= 3'd0;
            r_second <= 1'b0;
            r_chal   <= 8'd0;
            r_resp   <= 8'd0;
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_s3     <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_ack    <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            {r_s3, r_s2, r_s1} <= {r_s2, r_s1, done};
            r_ack <= 1'b0;
            // ACK still counts as busy, so an edge landing there is an overrun
            if (w_rise && r_state != S_IDLE) r_ovr <= 1'b1;
            if (r_state != S_IDLE && r_state != S_ACK) r_cnt <= w_bit_end ? RELOAD : r_cnt - 16'd1;
            case (r_state)
                S_IDLE: if (w_rise) begin
                    r_chal   <= challenge;
                    r_resp   <= response;
                    r_second <= 1'b0;
                    r_cnt    <= RELOAD;
                    r_tx     <= 1'b0;
                    r_busy   <= 1'b1;
                    r_state  <= S_START;
                end
                S_START: if (w_bit_end) begin
                    r_state <= S_DATA;
                    r_idx   <= 3'd0;
                    r_tx    <= w_byte[0];
                end
                S_DATA: if (w_bit_end) begin
                    r_idx <= r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef PUF_TX_PARITY_EN
                        r_state <= S_PARITY;
                        r_tx    <= ^w_byte;
`else
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
`endif
                    end else begin
                        r_tx <= w_byte[r_idx + 3'd1];
                    end
                end
`ifdef PUF_TX_PARITY_EN
                S_PARITY: if (w_bit_end) begin
                    r_state <= S_STOP;
                    r_tx    <= 1'b1;
                end
`endif
                S_STOP: if (w_bit_end) begin
                    if (r_second) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                    end else begin
                        r_second <= 1'b1;
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign computer_ack = r_ack;
    assign tx           = r_tx;
    assign busy         = r_busy;
    assign overrun      = r_ovr;
endmodule

// File: tb/tb_puf_resp_uart_tx.sv
// tb_puf_resp_uart_tx: random and directed transfers checked every cycle against a frame-level model.
module tb_puf_resp_uart_tx;
    localparam int CPB = 4;
`ifdef PUF_TX_PARITY_EN
    localparam int F   = 11;
    localparam bit PAR = 1'b1;
    localparam logic [0:21] LIT_A = 22'b0101001010100011110001;
    localparam logic [0:21] LIT_B = 22'b0111000001100000000001;
`else
    localparam int F   = 10;
    localparam bit PAR = 1'b0;
    localparam logic [0:21] LIT_A = {20'b01010010110001111001, 2'b00};
    localparam logic [0:21] LIT_B = {20'b01110000010000000001, 2'b00};
`endif
    localparam int L = 2 * F * CPB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       done;
    logic [7:0] challenge;
    logic [7:0] response;
    logic       computer_ack;
    logic       tx;
    logic       busy;
    logic       overrun;

    puf_resp_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .done(done), .challenge(challenge), .response(response),
        .computer_ack(computer_ack), .tx(tx), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_ack = 0;
    logic [3:0] dh = 4'b0;
    logic [7:0] chq = 8'd0;
    logic [7:0] rsq = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Per-edge history of what the design samples: done (zeroed while in reset) and the data inputs
    always @(posedge clk) begin
        cyc <= cyc + 1;
        dh  <= rst_n ? {dh[2:0], done} : 4'b0;
        chq <= challenge;
        rsq <= response;
    end

    // Model: a capture at edge t_cap makes the line replay frame bit k/CPB for k cycles after it
    logic fb [0:21];
    bit   m_act = 1'b0;
    bit   m_ovr = 1'b0;
    int   t_cap = 0;
    initial forever begin
        logic e_tx, e_busy, e_ack;
        int k;
        @(negedge clk);
        if (!rst_n) begin
            m_act = 1'b0;
            m_ovr = 1'b0;
            e_tx = 1'b1; e_busy = 1'b0; e_ack = 1'b0;
        end else begin
            if (dh[2] && !dh[3]) begin
                if (m_act && cyc - t_cap <= L + 1) m_ovr = 1'b1;
                else begin
                    m_act = 1'b1;
                    t_cap = cyc;
                    for (int b = 0; b < 2; b++) begin
                        logic [7:0] v;
                        v = b == 0 ? chq : rsq;
                        fb[b*F] = 1'b0;
                        for (int i = 0; i < 8; i++) fb[b*F+1+i] = v[i];
                        if (PAR) fb[b*F+9] = ^v;
                        fb[b*F+F-1] = 1'b1;
                    end
                end
            end
            k = cyc - t_cap;
            e_busy = m_act && k <= L;
            e_ack  = m_act && k == L;
            e_tx   = (m_act && k < L) ? fb[k/CPB] : 1'b1;
        end
        chk("tx", tx, e_tx);
        chk("busy", busy, e_busy);
        chk("ack", computer_ack, e_ack);
        chk("overrun", overrun, m_ovr);
        if (computer_ack === 1'b1) n_ack++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic xfer(input logic [7:0] c, input logic [7:0] r, input bit use_lit,
                        input logic [0:21] lit, input int g_lo, input int g_hi);
        int e0, rel, acks0;
        bit got;
        challenge = c; response = r; done = 1'b1;
        e0 = cyc + 1; acks0 = n_ack; got = 1'b0;
        for (int n = 0; n < 2 * L + 50 && !got; n++) begin
            tick(1);
            rel = cyc - e0;
            if (rel == 3) begin challenge = 8'hFF; response = 8'hFF; end
            else if (rel > 3) begin challenge = 8'($urandom); response = 8'($urandom); end
            if (rel == g_lo) done = 1'b0;
            if (rel == g_hi) done = 1'b1;
            if (use_lit && rel >= 2 && (rel - 2) % CPB == CPB / 2 && (rel - 2) / CPB < 2 * F)
                chk("lit_tx", tx, lit[(rel-2)/CPB]);
            if (computer_ack) begin
                got = 1'b1;
                chk("ack_latency", rel, L + 2);
            end
        end
        if (!got) chk("ack_timeout", 0, 1);
        tick(1);
        chk("ack_count", n_ack - acks0, 1);
    endtask

    initial begin
        int e0, acks0;
        bit got;
        rst_n = 1'b0; done = 1'b0; challenge = 8'd0; response = 8'd0;
        tick(4);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick(3);
        xfer(8'hA5, 8'h3C, 1'b1, LIT_A, -1, -1);
        done = 1'b0; tick(3);
        xfer(8'h07, 8'h00, 1'b1, LIT_B, -1, -1);
        acks0 = n_ack;
        tick(200);
        chk("held_no_retrig_busy", busy, 1'b0);
        chk("held_no_retrig_acks", n_ack - acks0, 0);
        done = 1'b0; tick(3);
        xfer(8'($urandom), 8'($urandom), 1'b0, LIT_A, -1, -1);
        done = 1'b0; tick(3);
        xfer(8'h5A, 8'hC3, 1'b0, LIT_A, 20, 23);
        chk("overrun_set", overrun, 1'b1);
        acks0 = n_ack;
        tick(100);
        chk("overrun_no_extra_ack", n_ack - acks0, 0);
        // Reset in the middle of response data bit 3; done stays high so release acts as a new edge
        done = 1'b0; tick(3);
        challenge = 8'($urandom); response = 8'($urandom); done = 1'b1;
        e0 = cyc + 1;
        while (cyc - e0 < 2 + (F + 4) * CPB + 1) tick(1);
        acks0 = n_ack;
        rst_n = 1'b0;
        tick(1);
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        tick(2);
        rst_n = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 2 * L + 50 && !got; n++) begin
            tick(1);
            if (computer_ack) got = 1'b1;
        end
        chk("post_reset_ack", got, 1'b1);
        tick(1);
        chk("post_reset_ack_count", n_ack - acks0, 1);
        chk("post_reset_overrun", overrun, 1'b0);
        done = 1'b0; tick(3);
        xfer(8'h81, 8'h18, 1'b0, LIT_A, L - 3, L);
        tick(3);
        chk("ack_cycle_overrun", overrun, 1'b1);
        chk("ack_cycle_idle", busy, 1'b0);
        for (int j = 0; j < 8; j++) begin
            done = 1'b0;
            tick(1 + $urandom_range(0, 4));
            xfer(8'($urandom), 8'($urandom), 1'b0, LIT_A, -1, -1);
        end
        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/puf_resp_uart_tx.md
PUF_RESP_UART_TX -- requirements
Module: puf_resp_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, SHALL set clk cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 done  input  1  level from PUF serial stage; high = response valid.
REQ-005 challenge  input  8  challenge applied to the PUF for this response.
REQ-006 response  input  8  PUF response byte.
REQ-007 computer_ack  output  1  one-cycle pulse returned to the PUF stage to restart it.
REQ-008 tx  output  1  UART serial line, idle high, LSB first.
REQ-009 busy  output  1  high from capture until computer_ack pulse inclusive.
REQ-010 overrun  output  1  sticky flag: done rising edge arrived while busy.

Function
REQ-011 done SHALL be synchronized through two flops; a rising edge on the synchronized signal is the capture event.
REQ-012 On a capture event in IDLE, challenge and response SHALL be registered the same cycle the edge is detected; busy rises the next cycle.
REQ-013 FSM states: IDLE, START, DATA, PARITY, STOP, ACK; per-byte order START, DATA (8 bits), [PARITY], STOP.
REQ-014 Frame sequence SHALL be two bytes: captured challenge first, then captured response, with no idle bits between frames.
REQ-015 Each bit (start=0, data, parity, stop=1) SHALL hold tx for exactly CLKS_PER_BIT cycles via a 16-bit down-counter reloaded at each bit boundary.
REQ-016 A 3-bit bit index SHALL advance 0..7 in DATA; wrap from 7 exits to PARITY or STOP.
REQ-017 After the second STOP bit completes, the FSM SHALL enter ACK for one cycle, assert computer_ack, then return to IDLE.
REQ-018 Total capture-to-ack latency SHALL be 2*F*CLKS_PER_BIT + 2 cycles, F = 10 (11 with parity).
REQ-019 A capture event while busy SHALL be ignored (no recapture, frame unaffected) and SHALL set overrun; overrun clears only on reset.
REQ-020 done held high across ACK SHALL NOT retrigger; a new capture requires done low then high.
REQ-021 Simultaneous capture event and ACK cycle SHALL count as during busy (set overrun, ignore).
REQ-022 Input changes to challenge/response after capture SHALL NOT affect transmitted data.

Reset
REQ-023 rst_n low SHALL asynchronously force: FSM=IDLE, tx=1, busy=0, computer_ack=0, overrun=0, counters=0, sync flops=0, capture registers=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately with tx high; no computer_ack is generated for the aborted frame.
REQ-025 After rst_n deasserts, done already high SHALL be treated as a rising edge (sync flops reset to 0).

Configuration
REQ-026 Macro PUF_TX_PARITY_EN: when defined, an even-parity bit (XOR of 8 data bits) SHALL follow bit 7 in every frame and the PARITY state exists; when undefined, PARITY is removed, frames are 10 bits, ports unchanged.

Verification
REQ-027 CLKS_PER_BIT=4, no parity: challenge=0xA5, response=0x3C, done 0->1 -> tx serial 0,1,0,1,0,0,1,0,1,1 then 0,0,0,1,1,1,1,0,0,1, each bit 4 cycles; computer_ack one pulse 82 cycles after edge.
REQ-028 CLKS_PER_BIT=4, PUF_TX_PARITY_EN: challenge=0x07, response=0x00 -> parity bits 1 then 0; frames 11 bits; ack at 90 cycles.
REQ-029 Second done rising edge 20 cycles into a transfer -> overrun=1, transmitted bytes unchanged, exactly one ack.
REQ-030 rst_n pulsed low during response DATA bit 3 -> tx=1 and busy=0 within reset, no ack; new done edge afterward transmits fully.
REQ-031 done held high 200 cycles past ack -> no second transfer; done low 3 cycles then high -> new transfer starts.
REQ-032 challenge/response changed to 0xFF one cycle after capture -> transmitted bytes still match captured values.
